multiplier_datapath_taint_word: RTL and testbench
=================================================

Name: multiplier_datapath_taint_word

Overview:
- Datapath partner of the sequential shift-add multiplier control FSM. It is the consumer of that FSM's control strobes and their taint bits.
- Holds the multiplicand, the multiplier and the running-sum registers, performs LSB-first add/shift, and feeds the multiplier word and its taint back to the control.
- Carries one word-level taint bit per register, using the same conservative propagation as the control: a tainted enable taints its destination.
- Latches the final product and its taint when the control signals completion.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- multiplicand_in  in  WIDTH  operand A
- multiplicand_in_t  in  1  taint of operand A
- multiplier_in  in  WIDTH  operand B
- multiplier_in_t  in  1  taint of operand B
- mdld, mdld_t  in  1,1  load multiplicand register / taint
- mrld, mrld_t  in  1,1  load multiplier register / taint
- rsclear, rsclear_t  in  1,1  clear running sum / taint
- rsload, rsload_t  in  1,1  add multiplicand into running-sum upper half / taint
- rsshr, rsshr_t  in  1,1  shift running sum right by 1 / taint
- product_done, product_done_t  in  1,1  final cycle strobe from control / taint
- multiplier_reg  out  WIDTH  multiplier register contents, to control
- multiplier_reg_t  out  1  multiplier register taint
- product  out  2*WIDTH  latched product
- product_t  out  1  product taint
- product_valid  out  1  one-cycle pulse, product updated

Behaviour:
- Registers:
  - md[WIDTH-1:0], md_t
  - mr[WIDTH-1:0], mr_t
  - rs[2*WIDTH:0] (bit 2*WIDTH is the carry), rs_t
  - product, product_t, product_valid
- Reset: every register and every output is 0, including all taints. Reset overrides all strobes in the same cycle. Reset mid-multiply discards partial rs; the next product_done latches whatever rs then holds.
- All updates occur on posedge clk. Outputs come directly from registers; there is no combinational input-to-output path.
- md register:
  - if mdld: md <= multiplicand_in.
  - md_t <= mdld_t | (mdld ? multiplicand_in_t : md_t).
- mr register:
  - if mrld: mr <= multiplier_in.
  - mr_t <= mrld_t | (mrld ? multiplier_in_t : mr_t).
  - mr is never shifted; the control indexes its bits directly.
- rs register, priority rsclear > rsload > rsshr > hold:
  - clear: rs <= 0, source taint 0 (taint kill).
  - load: rs[2W:W] <= {1'b0, rs[2W-1:W]} + md, result W+1 bits; rs[W-1:0] held. Source taint = rs_t | md_t.
  - shift: rs <= rs >> 1, zero fill at MSB. Source taint = rs_t.
  - hold: rs unchanged, taint rs_t.
  - rs_t <= rsclear_t | rsload_t | rsshr_t | source taint of the selected operation.
  - Simultaneous strobes: only the highest-priority operation takes effect. The taints of all strobes still OR into rs_t.
- Product capture:
  - Sequence expected from the control: cycle k asserts mdld+mrld+rsclear; then WIDTH pairs of {rsload (if multiplier bit i set), rsshr}. The last rsshr coincides with product_done.
  - On product_done: product <= rs_next[2W-1:0], i.e. the value after this cycle's rs operation (post-shift).
  - product_t <= product_done_t | (product_done ? rs_t_next : product_t).
  - product_valid <= product_done, so it pulses for 1 cycle; its latency is 1 cycle after the product_done cycle.
  - product holds its value until the next product_done or rst.
- Arithmetic: unsigned. The carry bit absorbs add overflow and is shifted down on the following rsshr, so no overflow is possible.
- Taint never clears except via rst, rsclear with rsclear_t=0 (rs only), or a load with an untainted enable and untainted data.

Test Plan:
- WIDTH=4, A=3, B=5, all taints 0, full control sequence -> product=8'h0F, product_valid 1-cycle pulse one cycle after product_done, product_t=0, multiplier_reg=4'h5.
- A=15, B=15 (exercises carry) -> product=8'hE1, product_t=0. Also A=0, B=9 -> product=8'h00.
- A=6, multiplicand_in_t=1, B=2 -> md_t=1; after the first rsload, rs_t=1; product=8'h0C, product_t=1; mr_t=0.
- multiplier_in_t=1, B=4'hA -> multiplier_reg_t=1 the cycle after mrld. A subsequent rsclear with rsclear_t=0 gives rs_t=0 (taint kill). A load with mrld_t=0 and multiplier_in_t=0 clears mr_t.
- rsload_t=1 pulsed while rsload=0 -> rs value unchanged, rs_t=1. Assert rsclear and rsshr together -> rs=0, shift ignored.
- rst asserted mid-sequence after 2 add/shift pairs -> all registers 0 the next cycle, including product and product_t. A fresh 7*3 run -> product=8'h15.

Source files
------------

// File: rtl/multiplier_datapath_taint_word.sv
// multiplier_datapath_taint_word: shift-add multiplier datapath with word-level taint tracking
module multiplier_datapath_taint_word #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   multiplicand_in,
  input  logic               multiplicand_in_t,
  input  logic [WIDTH-1:0]   multiplier_in,
  input  logic               multiplier_in_t,
  input  logic               mdld,
  input  logic               mdld_t,
  input  logic               mrld,
  input  logic               mrld_t,
  input  logic               rsclear,
  input  logic               rsclear_t,
  input  logic               rsload,
  input  logic               rsload_t,
  input  logic               rsshr,
  input  logic               rsshr_t,
  input  logic               product_done,
  input  logic               product_done_t,
  output logic [WIDTH-1:0]   multiplier_reg,
  output logic               multiplier_reg_t,
  output logic [2*WIDTH-1:0] product,
  output logic               product_t,
  output logic               product_valid
);
  logic [WIDTH-1:0] md, mr;
  logic md_t, mr_t;
  logic [2*WIDTH:0] rs, rs_next;
  logic rs_t, rs_t_next;
  logic [WIDTH:0] sum;
  assign multiplier_reg = mr;
  assign multiplier_reg_t = mr_t;
  // next running sum: clear beats add beats shift; every strobe taint still taints rs
  always_comb begin
    sum = {1'b0, rs[2*WIDTH-1:WIDTH]} + {1'b0, md};
    rs_next = rsclear ? '0 : rsload ? {sum, rs[WIDTH-1:0]} : rsshr ? rs >> 1 : rs;
    rs_t_next = rsclear_t | rsload_t | rsshr_t | (rsclear ? 1'b0 : rsload ? (rs_t | md_t) : rs_t);
  end
  // operand registers, running sum and post-operation product capture
  always_ff @(posedge clk) begin
    if (rst) begin
      md <= '0;
      md_t <= 1'b0;
      mr <= '0;
      mr_t <= 1'b0;
      rs <= '0;
      rs_t <= 1'b0;
      product <= '0;
      product_t <= 1'b0;
      product_valid <= 1'b0;
    end else begin
      if (mdld) md <= multiplicand_in;
      md_t <= mdld_t | (mdld ? multiplicand_in_t : md_t);
      if (mrld) mr <= multiplier_in;
      mr_t <= mrld_t | (mrld ? multiplier_in_t : mr_t);
      rs <= rs_next;
      rs_t <= rs_t_next;
      if (product_done) product <= rs_next[2*WIDTH-1:0];
      product_t <= product_done_t | (product_done ? rs_t_next : product_t);
      product_valid <= product_done;
    end
  end
endmodule

// File: tb/tb_multiplier_datapath_taint_word.sv
// tb_multiplier_datapath_taint_word: scoreboard bench for the taint-tracking multiplier datapath
module tb_multiplier_datapath_taint_word;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] multiplicand_in, multiplier_in;
  logic multiplicand_in_t, multiplier_in_t;
  logic mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t;
  logic product_done, product_done_t;
  logic [W-1:0] multiplier_reg;
  logic multiplier_reg_t;
  logic [2*W-1:0] product;
  logic product_t, product_valid;
  int checks = 0;
  int errors = 0;
  logic [2*W:0] sb[$];

  always #5 clk = ~clk;

  multiplier_datapath_taint_word #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .multiplicand_in(multiplicand_in), .multiplicand_in_t(multiplicand_in_t),
    .multiplier_in(multiplier_in), .multiplier_in_t(multiplier_in_t),
    .mdld(mdld), .mdld_t(mdld_t), .mrld(mrld), .mrld_t(mrld_t),
    .rsclear(rsclear), .rsclear_t(rsclear_t), .rsload(rsload), .rsload_t(rsload_t),
    .rsshr(rsshr), .rsshr_t(rsshr_t),
    .product_done(product_done), .product_done_t(product_done_t),
    .multiplier_reg(multiplier_reg), .multiplier_reg_t(multiplier_reg_t),
    .product(product), .product_t(product_t), .product_valid(product_valid)
  );

  initial forever begin
    @(posedge clk);
    #1;
    if (product_valid) begin
      logic [2*W:0] e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: product=%h t=%b with empty scoreboard", product, product_t);
      end else begin
        e = sb.pop_front();
        if ({product_t, product} !== e) begin
          errors++;
          $display("FAIL product: got t=%b p=%h, want t=%b p=%h", product_t, product, e[2*W], e[2*W-1:0]);
        end
      end
    end
  end

  task automatic clr();
    mdld = 0; mdld_t = 0; mrld = 0; mrld_t = 0; rsclear = 0; rsclear_t = 0;
    rsload = 0; rsload_t = 0; rsshr = 0; rsshr_t = 0; product_done = 0; product_done_t = 0;
    multiplicand_in_t = 0; multiplier_in_t = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mult(input logic [W-1:0] a, input logic at, input logic [W-1:0] b, input logic bt);
    logic [2*W-1:0] p;
    logic pt;
    p = {4'b0, a} * {4'b0, b};
    pt = at && (b != 0);
    multiplicand_in = a; multiplicand_in_t = at; multiplier_in = b; multiplier_in_t = bt;
    mdld = 1; mrld = 1; rsclear = 1;
    cyc(); clr();
    for (int i = 0; i < W; i++) begin
      if (b[i]) begin
        rsload = 1;
        cyc(); clr();
        checks++;
        if (dut.rs_t !== at) begin
          errors++;
          $display("FAIL rs_t_after_load: got %b want %b", dut.rs_t, at);
        end
      end
      rsshr = 1;
      if (i == W - 1) begin
        product_done = 1;
        sb.push_back({pt, p});
      end
      cyc(); clr();
    end
    checks++;
    if (product_valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_latency: got %b want 1", product_valid);
    end
    checks++;
    if ({multiplier_reg_t, multiplier_reg} !== {bt, b}) begin
      errors++;
      $display("FAIL multiplier_reg: got t=%b %h want t=%b %h", multiplier_reg_t, multiplier_reg, bt, b);
    end
    cyc();
    checks++;
    if (product_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_pulse: got %b want 0", product_valid);
    end
  endtask

  task automatic test_reset();
    clr(); multiplicand_in = 0; multiplier_in = 0;
    rst = 1; cyc(); cyc(); rst = 0;
    checks++;
    if ({product, product_t, product_valid, multiplier_reg, multiplier_reg_t} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got p=%h t=%b v=%b mr=%h mrt=%b want all 0",
               product, product_t, product_valid, multiplier_reg, multiplier_reg_t);
    end
  endtask

  task automatic test_basic();
    run_mult(4'd3, 0, 4'd5, 0);
  endtask

  task automatic test_carry();
    run_mult(4'd15, 0, 4'd15, 0);
    run_mult(4'd0, 0, 4'd9, 0);
  endtask

  task automatic test_md_taint();
    run_mult(4'd6, 1, 4'd2, 0);
    checks++;
    if ({dut.md_t, dut.mr_t} !== 2'b10) begin
      errors++;
      $display("FAIL md_mr_taint: got md_t=%b mr_t=%b want 1 0", dut.md_t, dut.mr_t);
    end
  endtask

  task automatic test_taint_strobes();
    multiplicand_in = 4'd3; multiplier_in = 4'hA; multiplier_in_t = 1;
    mdld = 1; mrld = 1; rsclear = 1; rsclear_t = 1;
    cyc(); clr();
    checks++;
    if ({multiplier_reg_t, multiplier_reg, dut.rs_t, dut.md_t} !== {1'b1, 4'hA, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mr_taint_load: got mrt=%b mr=%h rst=%b mdt=%b want 1 a 1 0",
               multiplier_reg_t, multiplier_reg, dut.rs_t, dut.md_t);
    end
    rsclear = 1;
    cyc(); clr();
    checks++;
    if (dut.rs_t !== 1'b0) begin
      errors++;
      $display("FAIL taint_kill: got rs_t=%b want 0", dut.rs_t);
    end
    rsload = 1;
    cyc(); clr();
    rsload_t = 1;
    cyc(); clr();
    checks++;
    if ({dut.rs_t, dut.rs} !== {1'b1, 9'h030}) begin
      errors++;
      $display("FAIL tainted_idle_strobe: got rs_t=%b rs=%h want 1 030", dut.rs_t, dut.rs);
    end
    rsclear = 1; rsshr = 1;
    cyc(); clr();
    checks++;
    if ({dut.rs_t, dut.rs} !== 10'h0) begin
      errors++;
      $display("FAIL clear_over_shift: got rs_t=%b rs=%h want 0 000", dut.rs_t, dut.rs);
    end
    mrld_t = 1;
    cyc(); clr();
    checks++;
    if ({multiplier_reg_t, multiplier_reg} !== {1'b1, 4'hA}) begin
      errors++;
      $display("FAIL mrld_t_only: got t=%b mr=%h want 1 a", multiplier_reg_t, multiplier_reg);
    end
    multiplier_in = 4'h6; mrld = 1;
    cyc(); clr();
    checks++;
    if ({multiplier_reg_t, multiplier_reg} !== {1'b0, 4'h6}) begin
      errors++;
      $display("FAIL mr_taint_clear: got t=%b mr=%h want 0 6", multiplier_reg_t, multiplier_reg);
    end
  endtask

  task automatic test_reset_mid();
    run_mult(4'd6, 1, 4'd2, 0);
    multiplicand_in = 4'd15; multiplicand_in_t = 1; multiplier_in = 4'd15; multiplier_in_t = 1;
    mdld = 1; mrld = 1; rsclear = 1;
    cyc(); clr();
    for (int i = 0; i < 2; i++) begin
      rsload = 1; cyc(); clr();
      rsshr = 1; cyc(); clr();
    end
    rst = 1; cyc(); rst = 0;
    checks++;
    if ({product, product_t, product_valid, multiplier_reg, multiplier_reg_t,
         dut.rs, dut.rs_t, dut.md, dut.md_t} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got p=%h t=%b v=%b mr=%h mrt=%b rs=%h rst=%b md=%h mdt=%b want all 0",
               product, product_t, product_valid, multiplier_reg, multiplier_reg_t,
               dut.rs, dut.rs_t, dut.md, dut.md_t);
    end
    run_mult(4'd7, 0, 4'd3, 0);
  endtask

  task automatic test_drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      cyc();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d products pending, want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_md_taint();
    test_taint_strobes();
    test_reset_mid();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
